// File: rtl/instr_fetch.sv
`default_nettype none
// ============================================================================
// Module   : instr_fetch
// Purpose  : Front-end of the single-issue core. Owns the PC, issues one
//            32-bit instruction read at a time to instruction memory and
//            hands each fetched word to the decoder over valid/ready.
//            Handles branch redirects and halt requests from the execute side.
//            Stops prefetching after it delivers a HALT word (opcode 5'h1F).
// Ports    : clk/reset            - core clock, synchronous active-high reset
//            mem_req_*            - read request channel (valid/ready/addr)
//            mem_rsp_*            - read response (valid/data), one outstanding
//            instr_*              - fetched word and its PC toward the decoder
//            redirect_valid/_pc   - taken branch, restart fetch at redirect_pc
//            halt                 - stop fetching
//            halted               - fetch stopped, nothing outstanding
//            err_misaligned       - sticky, a redirect target had bits [1:0]!=0
// Revision : 1.0 - initial release
// ============================================================================
module instr_fetch #(
    parameter int unsigned       ADDR_W   = 64,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(64'h2000)
) (
    input  logic              clk,
    input  logic              reset,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [ADDR_W-1:0] mem_req_addr,
    input  logic              mem_rsp_valid,
    input  logic [31:0]       mem_rsp_data,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [31:0]       instr,
    output logic [ADDR_W-1:0] instr_pc,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    input  logic              halt,
    output logic              halted,
    output logic              err_misaligned
);

    localparam logic [4:0] c_OPC_HALT = 5'h1F;

    typedef enum logic [1:0] {
        S_REQ    = 2'd0,
        S_WAIT   = 2'd1,
        S_HOLD   = 2'd2,
        S_HALTED = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] req_pc_q, req_pc_d;
    logic [ADDR_W-1:0] instr_pc_q, instr_pc_d;
    logic [31:0]       instr_q, instr_d;
    logic              drop_q, drop_d;       // outstanding response is stale
    logic              halt_pend_q, halt_pend_d;
    logic              err_q, err_d;

    // A redirect only counts when the front-end is still running and no halt
    // arrives in the same cycle (halt has priority).
    logic              w_redir_take;
    logic [ADDR_W-1:0] w_redir_pc;

    assign w_redir_take = redirect_valid && !halt && (state_q != S_HALTED);
    assign w_redir_pc   = {redirect_pc[ADDR_W-1:2], 2'b00};

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_REQ;
            pc_q        <= RESET_PC;
            req_pc_q    <= '0;
            instr_q     <= '0;
            instr_pc_q  <= '0;
            drop_q      <= 1'b0;
            halt_pend_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            req_pc_q    <= req_pc_d;
            instr_q     <= instr_d;
            instr_pc_q  <= instr_pc_d;
            drop_q      <= drop_d;
            halt_pend_q <= halt_pend_d;
            err_q       <= err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        req_pc_d    = req_pc_q;
        instr_d     = instr_q;
        instr_pc_d  = instr_pc_q;
        drop_d      = drop_q;
        halt_pend_d = halt_pend_q;
        err_d       = err_q;

        if (w_redir_take) begin
            pc_d = w_redir_pc;
            if (redirect_pc[1:0] != 2'b00) begin
                err_d = 1'b1;
            end
        end

        case (state_q)
            S_REQ: begin
                if (halt) begin
                    // A request the memory accepts in the halt cycle still
                    // returns data; wait it out before reporting halted.
                    if (mem_req_ready) begin
                        state_d     = S_WAIT;
                        req_pc_d    = pc_q;
                        drop_d      = 1'b1;
                        halt_pend_d = 1'b1;
                    end else begin
                        state_d = S_HALTED;
                    end
                end else if (mem_req_ready) begin
                    state_d  = S_WAIT;
                    req_pc_d = pc_q;
                    // Request launched with the old PC while redirecting.
                    drop_d   = redirect_valid;
                end
            end

            S_WAIT: begin
                if (halt) begin
                    drop_d      = 1'b1;
                    halt_pend_d = 1'b1;
                    if (mem_rsp_valid) begin
                        state_d     = S_HALTED;
                        drop_d      = 1'b0;
                        halt_pend_d = 1'b0;
                    end
                end else if (mem_rsp_valid) begin
                    if (drop_q || redirect_valid) begin
                        drop_d      = 1'b0;
                        halt_pend_d = 1'b0;
                        state_d     = halt_pend_q ? S_HALTED : S_REQ;
                    end else begin
                        instr_d    = mem_rsp_data;
                        instr_pc_d = req_pc_q;
                        pc_d       = req_pc_q + ADDR_W'(4);
                        state_d    = S_HOLD;
                    end
                end else if (redirect_valid) begin
                    drop_d = 1'b1;
                end
            end

            S_HOLD: begin
                if (halt) begin
                    state_d = S_HALTED;
                end else if (redirect_valid) begin
                    // Held word is on the wrong path even if consumed now.
                    state_d = S_REQ;
                end else if (instr_ready) begin
                    state_d = (instr_q[31:27] == c_OPC_HALT) ? S_HALTED : S_REQ;
                end
            end

            default: begin
                state_d = S_HALTED;
            end
        endcase
    end

    // Request is masked during reset so the first one appears only in the
    // cycle after reset deasserts.
    assign mem_req_valid  = (state_q == S_REQ) && !reset;
    assign mem_req_addr   = pc_q;
    assign instr_valid    = (state_q == S_HOLD);
    assign instr          = instr_q;
    assign instr_pc       = instr_pc_q;
    assign halted         = (state_q == S_HALTED);
    assign err_misaligned = err_q;

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_instr_fetch
// Purpose  : Self-checking bench for instr_fetch: cycle tables for the
//            directed scenarios, a wrap-around instance, and a randomized run
//            against a transaction-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_instr_fetch;

    localparam logic [63:0] c_WRAP_PC = 64'hFFFF_FFFF_FFFF_FFFC;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, mem_req_ready, mem_rsp_valid, instr_ready, redirect_valid, halt;
    logic [31:0] mem_rsp_data;
    logic [63:0] redirect_pc;
    logic        mem_req_valid, instr_valid, halted, err_misaligned;
    logic [63:0] mem_req_addr, instr_pc;
    logic [31:0] instr;

    instr_fetch dut (
        .clk(clk), .reset(reset),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr), .instr_pc(instr_pc),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .halt(halt), .halted(halted), .err_misaligned(err_misaligned)
    );

    // Second instance exercising PC wrap from the top of the address space.
    logic        rst2, rsp_v2;
    logic        req_v2, iv2, halted2, err2;
    logic [63:0] addr2, ipc2;
    logic [31:0] instr2;

    instr_fetch #(.ADDR_W(64), .RESET_PC(c_WRAP_PC)) dut2 (
        .clk(clk), .reset(rst2),
        .mem_req_valid(req_v2), .mem_req_ready(1'b1), .mem_req_addr(addr2),
        .mem_rsp_valid(rsp_v2), .mem_rsp_data(32'h0),
        .instr_valid(iv2), .instr_ready(1'b1), .instr(instr2), .instr_pc(ipc2),
        .redirect_valid(1'b0), .redirect_pc(64'h0),
        .halt(1'b0), .halted(halted2), .err_misaligned(err2)
    );

    // One-cycle-latency memory for the wrap instance.
    always @(posedge clk) rsp_v2 <= rst2 ? 1'b0 : req_v2;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // ---------------- directed cycle table ----------------
    typedef struct {
        logic rst, rdy, rspv; logic [31:0] rspd; logic irdy, redir; logic [63:0] rpc; logic hlt;
        logic ckd, e_rv; logic [63:0] e_ra; logic e_iv; logic [31:0] e_in; logic [63:0] e_ipc;
        logic e_hl, e_er;
    } vec_t;
    vec_t vq[$];

    task automatic add(input bit rst, input bit rdy, input bit rspv, input logic [31:0] rspd,
                       input bit irdy, input bit redir, input logic [63:0] rpc, input bit hlt,
                       input bit ckd, input bit rv, input logic [63:0] ra, input bit iv,
                       input logic [31:0] in, input logic [63:0] ipc, input bit hl, input bit er);
        vec_t v;
        v.rst = rst; v.rdy = rdy; v.rspv = rspv; v.rspd = rspd; v.irdy = irdy; v.redir = redir;
        v.rpc = rpc; v.hlt = hlt; v.ckd = ckd; v.e_rv = rv; v.e_ra = ra; v.e_iv = iv;
        v.e_in = in; v.e_ipc = ipc; v.e_hl = hl; v.e_er = er;
        vq.push_back(v);
    endtask

    task automatic build_table();
        //  rst rdy rspv rspd          irdy redir rpc     hlt | ckd rv ra      iv in            ipc     hl er
        add(1, 0, 0, 0,            0, 0, 0,       0,   1, 0, 0,       0, 0,            0,      0, 0); // reset values
        add(0, 1, 0, 0,            0, 0, 0,       0,   0, 1, 'h2000,  0, 0,            0,      0, 0);
        add(0, 0, 1, 'h00000000,   0, 0, 0,       0,   0, 0, 0,       0, 0,            0,      0, 0);
        add(0, 0, 0, 0,            1, 0, 0,       0,   0, 0, 0,       1, 'h00000000,   'h2000, 0, 0);
        add(0, 1, 0, 0,            0, 0, 0,       0,   0, 1, 'h2004,  0, 0,            0,      0, 0);
        add(0, 0, 1, 'h08400000,   0, 0, 0,       0,   0, 0, 0,       0, 0,            0,      0, 0);
        add(0, 0, 0, 0,            1, 0, 0,       0,   0, 0, 0,       1, 'h08400000,   'h2004, 0, 0);
        add(0, 1, 0, 0,            0, 0, 0,       0,   0, 1, 'h2008,  0, 0,            0,      0, 0);
        add(0, 0, 1, 'h0A000005,   0, 0, 0,       0,   0, 0, 0,       0, 0,            0,      0, 0);
        for (int k = 0; k < 5; k++)   // backpressure: held word stable, no request
            add(0, 1, 0, 0,        0, 0, 0,       0,   0, 0, 0,       1, 'h0A000005,   'h2008, 0, 0);
        add(0, 1, 0, 0,            1, 0, 0,       0,   0, 0, 0,       1, 'h0A000005,   'h2008, 0, 0);
        add(0, 0, 0, 0,            0, 0, 0,       0,   0, 1, 'h200C,  0, 0,            0,      0, 0);
        add(0, 1, 0, 0,            0, 0, 0,       0,   0, 1, 'h200C,  0, 0,            0,      0, 0);
        add(0, 0, 0, 0,            0, 1, 'h3000,  0,   0, 0, 0,       0, 0,            0,      0, 0); // redirect in WAIT
        add(0, 0, 1, 'hF8000000,   0, 0, 0,       0,   0, 0, 0,       0, 0,            0,      0, 0); // stale, dropped
        add(0, 1, 0, 0,            0, 0, 0,       0,   0, 1, 'h3000,  0, 0,            0,      0, 0);
        add(0, 0, 1, 'h10000001,   0, 0, 0,       0,   0, 0, 0,       0, 0,            0,      0, 0);
        add(0, 0, 0, 0,            0, 1, 'h3003,  0,   0, 0, 0,       1, 'h10000001,   'h3000, 0, 0); // misaligned in HOLD
        add(0, 1, 0, 0,            0, 0, 0,       0,   0, 1, 'h3000,  0, 0,            0,      0, 1);
        add(0, 0, 1, 'hF8000000,   0, 0, 0,       0,   0, 0, 0,       0, 0,            0,      0, 1);
        add(0, 0, 0, 0,            1, 0, 0,       0,   0, 0, 0,       1, 'hF8000000,   'h3000, 0, 1); // HALT word delivered
        add(0, 1, 0, 0,            0, 0, 0,       0,   0, 0, 0,       0, 0,            0,      1, 1);
        add(0, 1, 0, 0,            0, 1, 'h4000,  0,   0, 0, 0,       0, 0,            0,      1, 1);
        add(0, 1, 0, 0,            0, 0, 0,       0,   0, 0, 0,       0, 0,            0,      1, 1);
        add(1, 0, 0, 0,            0, 0, 0,       0,   0, 0, 0,       0, 0,            0,      1, 1);
        add(1, 0, 0, 0,            0, 0, 0,       0,   1, 0, 0,       0, 0,            0,      0, 0);
        add(0, 1, 0, 0,            0, 0, 0,       0,   0, 1, 'h2000,  0, 0,            0,      0, 0);
        add(0, 0, 1, 'h20000000,   0, 0, 0,       0,   0, 0, 0,       0, 0,            0,      0, 0);
        add(0, 0, 0, 0,            0, 1, 'h4000,  1,   0, 0, 0,       1, 'h20000000,   'h2000, 0, 0); // halt+redirect in HOLD
        add(0, 1, 0, 0,            0, 0, 0,       0,   0, 0, 0,       0, 0,            0,      1, 0);
        add(0, 1, 0, 0,            0, 0, 0,       0,   0, 0, 0,       0, 0,            0,      1, 0);
        add(1, 0, 0, 0,            0, 0, 0,       0,   0, 0, 0,       0, 0,            0,      1, 0);
        add(1, 0, 0, 0,            0, 0, 0,       0,   1, 0, 0,       0, 0,            0,      0, 0);
        add(0, 1, 0, 0,            0, 0, 0,       0,   0, 1, 'h2000,  0, 0,            0,      0, 0);
        add(0, 0, 1, 'h30000000,   0, 0, 0,       0,   0, 0, 0,       0, 0,            0,      0, 0);
        add(0, 0, 0, 0,            1, 0, 0,       0,   0, 0, 0,       1, 'h30000000,   'h2000, 0, 0);
        add(0, 1, 0, 0,            0, 0, 0,       0,   0, 1, 'h2004,  0, 0,            0,      0, 0);
        add(1, 0, 0, 0,            0, 0, 0,       0,   0, 0, 0,       0, 0,            0,      0, 0); // reset in WAIT
        add(0, 1, 0, 0,            0, 0, 0,       0,   1, 1, 'h2000,  0, 0,            0,      0, 0);
        add(0, 0, 0, 0,            0, 0, 0,       1,   0, 0, 0,       0, 0,            0,      0, 0); // halt in WAIT
        add(0, 0, 0, 0,            0, 0, 0,       0,   0, 0, 0,       0, 0,            0,      0, 0);
        add(0, 0, 1, 'h50000000,   0, 0, 0,       0,   0, 0, 0,       0, 0,            0,      0, 0);
        add(0, 1, 0, 0,            1, 0, 0,       0,   0, 0, 0,       0, 0,            0,      1, 0);
    endtask

    // ---------------- reference model (transaction level) ----------------
    bit          m_issue, m_out, m_stale, m_stop_pend, m_show, m_stopped, m_err;
    logic [63:0] m_pc, m_req_pc, m_ipc;
    logic [31:0] m_instr;

    task automatic model_step();
        bit          take;
        logic [63:0] npc;
        if (reset) begin
            m_issue = 1; m_out = 0; m_stale = 0; m_stop_pend = 0; m_show = 0; m_stopped = 0;
            m_err = 0; m_pc = 64'h2000; m_req_pc = '0; m_ipc = '0; m_instr = '0;
        end else if (!m_stopped) begin
            take = redirect_valid && !halt;
            npc  = take ? (redirect_pc & ~64'h3) : m_pc;
            if (take && redirect_pc[1:0] != 2'b00) m_err = 1;
            if (m_issue) begin
                if (mem_req_ready) begin
                    m_issue = 0; m_out = 1; m_req_pc = m_pc;
                    m_stale = halt || redirect_valid; m_stop_pend = halt;
                end else if (halt) begin
                    m_issue = 0; m_stopped = 1;
                end
                m_pc = npc;
            end else if (m_out) begin
                if (mem_rsp_valid) begin
                    m_out = 0;
                    if (m_stale || halt || redirect_valid) begin
                        if (m_stop_pend || halt) m_stopped = 1; else m_issue = 1;
                        m_stale = 0; m_stop_pend = 0; m_pc = npc;
                    end else begin
                        m_show = 1; m_instr = mem_rsp_data; m_ipc = m_req_pc; m_pc = m_req_pc + 64'd4;
                    end
                end else begin
                    if (halt) begin m_stale = 1; m_stop_pend = 1; end
                    if (take) m_stale = 1;
                    m_pc = npc;
                end
            end else if (m_show) begin
                if (halt) begin
                    m_show = 0; m_stopped = 1;
                end else if (take) begin
                    m_show = 0; m_issue = 1; m_pc = npc;
                end else if (instr_ready) begin
                    m_show = 0;
                    if (m_instr[31:27] == 5'h1F) m_stopped = 1; else m_issue = 1;
                end
            end
        end
    endtask

    // random memory: one outstanding request, latency 1..3
    bit          mem_pend;
    int          mem_cnt;
    logic [31:0] mem_pd;

    function automatic logic [31:0] gen_word();
        logic [31:0] w;
        w = $urandom;
        if ($urandom % 10 == 0) w[31:27] = 5'h1F;
        else if (w[31:27] == 5'h1F) w[31:27] = 5'h00;
        return w;
    endfunction

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish, got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        bit seen_req, seen_ins;
        int stuck;
        reset = 1; mem_req_ready = 0; mem_rsp_valid = 0; mem_rsp_data = '0;
        instr_ready = 0; redirect_valid = 0; redirect_pc = '0; halt = 0; rst2 = 1;
        build_table();
        @(posedge clk);

        for (int i = 0; i < vq.size(); i++) begin
            @(posedge clk); #1;
            reset = vq[i].rst; mem_req_ready = vq[i].rdy; mem_rsp_valid = vq[i].rspv;
            mem_rsp_data = vq[i].rspd; instr_ready = vq[i].irdy; redirect_valid = vq[i].redir;
            redirect_pc = vq[i].rpc; halt = vq[i].hlt;
            @(negedge clk);
            chk($sformatf("v%0d.req_valid", i), mem_req_valid, vq[i].e_rv);
            if (vq[i].e_rv) chk($sformatf("v%0d.req_addr", i), mem_req_addr, vq[i].e_ra);
            chk($sformatf("v%0d.instr_valid", i), instr_valid, vq[i].e_iv);
            if (vq[i].e_iv || vq[i].ckd) begin
                chk($sformatf("v%0d.instr", i), instr, vq[i].e_in);
                chk($sformatf("v%0d.instr_pc", i), instr_pc, vq[i].e_ipc);
            end
            chk($sformatf("v%0d.halted", i), halted, vq[i].e_hl);
            chk($sformatf("v%0d.err", i), err_misaligned, vq[i].e_er);
        end

        // halted front-end stays quiet
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            mem_req_ready = 1; instr_ready = 1; mem_rsp_valid = 0; halt = 0; redirect_valid = 0;
            @(negedge clk);
            chk($sformatf("halted_quiet%0d.req_valid", c), mem_req_valid, 1'b0);
            chk($sformatf("halted_quiet%0d.halted", c), halted, 1'b1);
        end

        // wrap from the top of the address space
        @(posedge clk); #1; rst2 = 0;
        @(negedge clk);
        chk("wrap.first_req_valid", req_v2, 1'b1);
        chk("wrap.first_req_addr", addr2, c_WRAP_PC);
        seen_req = 0; seen_ins = 0;
        for (int c = 0; c < 12 && !seen_req; c++) begin
            @(posedge clk); @(negedge clk);
            if (iv2) begin
                chk("wrap.instr_pc", ipc2, c_WRAP_PC);
                chk("wrap.instr", instr2, 32'h0);
                seen_ins = 1;
            end
            if (req_v2) begin
                chk("wrap.second_req_addr", addr2, 64'h0);
                seen_req = 1;
            end
        end
        chk("wrap.instr_seen", seen_ins, 1'b1);
        chk("wrap.second_req_seen", seen_req, 1'b1);
        chk("wrap.halted", halted2, 1'b0);
        chk("wrap.err", err2, 1'b0);
        @(posedge clk); #1; rst2 = 1;

        // randomized run against the reference model
        @(posedge clk); #1;
        reset = 1; mem_req_ready = 0; mem_rsp_valid = 0; instr_ready = 0;
        redirect_valid = 0; halt = 0; mem_pend = 0;
        @(negedge clk);
        model_step();
        stuck = 0;
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk); #1;
            stuck = m_stopped ? stuck + 1 : 0;
            reset = ($urandom % 200 == 0) || (stuck > 6);
            mem_rsp_valid = 0;
            mem_rsp_data  = $urandom;
            if (reset) begin
                mem_pend = 0;
            end else if (mem_pend) begin
                mem_cnt--;
                if (mem_cnt == 0) begin
                    mem_rsp_valid = 1; mem_rsp_data = mem_pd; mem_pend = 0;
                end
            end
            mem_req_ready  = ($urandom % 4 != 0);
            instr_ready    = ($urandom % 3 != 0);
            redirect_valid = ($urandom % 12 == 0);
            redirect_pc    = {$urandom, $urandom};
            if ($urandom % 4 != 0) redirect_pc[1:0] = 2'b00;
            halt           = ($urandom % 40 == 0);
            @(negedge clk);
            chk($sformatf("r%0d.req_valid", c), mem_req_valid, m_issue && !reset);
            if (m_issue && !reset) chk($sformatf("r%0d.req_addr", c), mem_req_addr, m_pc);
            chk($sformatf("r%0d.instr_valid", c), instr_valid, m_show);
            if (m_show) begin
                chk($sformatf("r%0d.instr", c), instr, m_instr);
                chk($sformatf("r%0d.instr_pc", c), instr_pc, m_ipc);
            end
            chk($sformatf("r%0d.halted", c), halted, m_stopped);
            chk($sformatf("r%0d.err", c), err_misaligned, m_err);
            if (!reset && mem_req_valid && mem_req_ready) begin
                mem_pend = 1; mem_cnt = $urandom_range(1, 3); mem_pd = gen_word();
            end
            model_step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
